fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one `fifo` write port between NUM_SRC AXI-Stream sources.
- Sits upstream of the `fifo` instance in the axis_udp_filter datapath.
- Holds a grant from the first beat of a packet until its tlast beat, so packets are never interleaved in the FIFO.
- Stores tlast alongside data: FIFO word = {tlast, tdata}, so the FIFO is instantiated with DATA_WIDTH + 1.

Parameters:
- NUM_SRC, 4: number of requesting sources; 2..16.
- DATA_WIDTH, 32: tdata width per source.
- CNT_WIDTH, 32: width of the completed-packet counter.

Ports:
- clk_i  in  1  clock.
- s_rst_n_i  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata_i  in  NUM_SRC*DATA_WIDTH  source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid_i  in  NUM_SRC  per-source valid.
- s_axis_tlast_i  in  NUM_SRC  per-source end of packet.
- s_axis_tready_o  out  NUM_SRC  per-source ready.
- fifo_wr_en_o  out  1  to fifo wr_en_i.
- fifo_data_o  out  DATA_WIDTH+1  to fifo data_i; MSB = tlast.
- fifo_full_i  in  1  from fifo full_o.
- grant_o  out  NUM_SRC  one-hot current grant; all zero when idle.
- busy_o  out  1  high while a packet is in transfer.
- pkt_cnt_o  out  CNT_WIDTH  packets fully written; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, s_rst_n_i = 0): state = IDLE.
  - grant_o = 0, busy_o = 0, pkt_cnt_o = 0.
  - s_axis_tready_o = 0, fifo_wr_en_o = 0.
  - Round-robin pointer last = NUM_SRC-1, so source 0 has top priority first.
- Reset mid-packet: the partial packet stays in the FIFO; no recovery inside this block. Flushing the FIFO is the system's job.
- FSM:
  - IDLE: if any tvalid is high, select the first requester scanning last+1, last+2, … modulo NUM_SRC.
    - Register the grant, go to PASS. This costs 1 cycle of arbitration latency.
    - No tready and no write are issued in IDLE.
  - PASS, with granted index g:
    - s_axis_tready_o[g] = !fifo_full_i (combinational). All other tready bits = 0.
    - fifo_wr_en_o = tvalid[g] & !fifo_full_i (combinational).
    - fifo_data_o = {tlast[g], tdata[g]}. It is driven continuously; it is meaningful only with wr_en.
    - On a beat accepted with tlast[g] = 1: next state IDLE, last <= g, pkt_cnt_o += 1, grant cleared next cycle.
- Throughput:
  - One beat per cycle within a packet.
  - One idle cycle between packets (the IDLE arbitration cycle).
- Boundaries:
  - fifo_full_i high mid-packet: tready[g] = 0, no write, grant held. Resume the cycle after full drops.
  - tvalid[g] low mid-packet: grant held and no write. Other sources are never granted until tlast is accepted.
  - Single-beat packet (tvalid & tlast on first PASS cycle): 1 write; state is IDLE the next cycle.
  - Only one source requesting repeatedly: it is re-granted every packet, with a 1-cycle gap.
  - fifo_full_i while IDLE: arbitration still proceeds. The first write stalls in PASS.
  - No write is ever issued when fifo_full_i = 1. The FIFO's overflow protection is not relied on.
- busy_o = (state == PASS). grant_o is registered and valid only in PASS.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, PASS} arb_state_t.
  - Function rr_pick (rotating-priority one-hot select).
- Index width is $clog2(NUM_SRC), a local parameter in the module because it depends on parameters.
- Sub-module rr_arbiter, combinational:
  - Inputs: req[NUM_SRC], last-grant index.
  - Outputs: one-hot gnt and gnt index.
  - The top module holds the FSM, grant register, mux and counter.

Test Plan:
- Reset, then source 0 sends 3 beats (0xA0..0xA2, tlast on 0xA2) → grant_o = 0001 one cycle after tvalid; 3 writes; FIFO words = 0x0_000000A0, 0x0_000000A1, 0x1_000000A2; pkt_cnt_o = 1.
- Sources 0, 1 and 3 all request with 2-beat packets, last = 3 → grants in order 0, 1, 3; no interleaving in FIFO readout; 1 idle cycle between packets; pkt_cnt_o = 3.
- Fairness: after source 1 finishes, sources 1 and 2 both request → source 2 is granted before source 1.
- fifo_full_i forced high for 4 cycles mid-packet of source 2 → tready[2] = 0 and wr_en = 0 for those 4 cycles; grant held; the packet completes afterwards with no lost or duplicated beat.
- Granted source drops tvalid for 2 cycles mid-packet while source 0 requests → source 0 is not granted until the granted source's tlast is accepted.
- s_rst_n_i asserted asynchronously mid-packet (between clock edges) → grant_o, busy_o, tready and wr_en go 0 immediately; pkt_cnt_o = 0; after release source 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet-atomic FIFO write arbiter.
//   arb_state_t : IDLE (arbitrating) / PASS (streaming the granted packet)
//   rr_pick     : rotating-priority pick over up to MAX_SRC requesters.
//                 Returns {found, index}.
package fifo_arb_pkg;

  typedef enum logic {IDLE, PASS} arb_state_t;

  localparam int MAX_SRC = 16;

  // Scans last+1, last+2, ... modulo n and returns the first requester.
  // last < n and i <= n, so one conditional subtraction does the modulo.
  function automatic logic [4:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [3:0]         last,
                                         input logic [4:0]         n);
    logic       found;
    logic [3:0] idx;
    logic [4:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= MAX_SRC; i++) begin
      if (5'(i) <= n) begin
        cand = 5'(last) + 5'(i);
        if (cand >= n) cand = cand - n;
        if (!found && req[cand[3:0]]) begin
          found = 1'b1;
          idx   = cand[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin select.
//   req_i      : per-source request
//   last_i     : index of the most recently served source
//   gnt_o      : one-hot winner (all zero when nothing requests)
//   gnt_idx_o  : binary index of the winner
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [4:0] w_pick;

  assign w_pick    = rr_pick(MAX_SRC'(req_i), 4'(last_i), 5'(NUM_SRC));
  assign gnt_idx_o = IDX_W'(w_pick[3:0]);

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_pick[4] && (w_pick[3:0] == 4'(k))) gnt_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between
// NUM_SRC AXI-Stream sources. A grant is held from the first beat of a
// packet until its tlast beat is accepted; FIFO word = {tlast, tdata}.
//   clk_i, s_rst_n_i     : clock, async active-low reset
//   s_axis_t*            : per-source stream inputs / tready outputs
//   fifo_wr_en_o/data_o  : FIFO write port (data MSB = tlast)
//   fifo_full_i          : FIFO full; no write is issued while high
//   grant_o, busy_o      : one-hot grant (zero when idle), PASS indicator
//   pkt_cnt_o            : completed packets, wraps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          s_rst_n_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid_i,
  input  logic [NUM_SRC-1:0]            s_axis_tlast_i,
  output logic [NUM_SRC-1:0]            s_axis_tready_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH:0]           fifo_data_o,
  input  logic                          fifo_full_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t             r_state;
  logic [NUM_SRC-1:0]     r_grant;
  logic [IDX_W-1:0]       r_gidx;
  logic [IDX_W-1:0]       r_last;
  logic [CNT_WIDTH-1:0]   r_pkt_cnt;

  logic [NUM_SRC-1:0]     w_arb_gnt;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_pass;
  logic                   w_tvalid_g;
  logic                   w_tlast_g;
  logic [DATA_WIDTH-1:0]  w_tdata_g;
  logic                   w_accept;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (s_axis_tvalid_i),
    .last_i    (r_last),
    .gnt_o     (w_arb_gnt),
    .gnt_idx_o (w_arb_idx)
  );

  // Mux of the granted source; compare-based so no out-of-range index
  // arises for non-power-of-two NUM_SRC.
  always_comb begin
    w_tvalid_g = 1'b0;
    w_tlast_g  = 1'b0;
    w_tdata_g  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_gidx == IDX_W'(k)) begin
        w_tvalid_g = s_axis_tvalid_i[k];
        w_tlast_g  = s_axis_tlast_i[k];
        w_tdata_g  = s_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_pass   = (r_state == PASS);
  assign w_accept = w_pass & w_tvalid_g & ~fifo_full_i;

  // r_grant is zero outside PASS, so the mask alone gates tready in IDLE.
  assign s_axis_tready_o = r_grant & {NUM_SRC{w_pass & ~fifo_full_i}};
  assign fifo_wr_en_o    = w_accept;
  assign fifo_data_o     = {w_tlast_g, w_tdata_g};
  assign grant_o         = r_grant;
  assign busy_o          = w_pass;
  assign pkt_cnt_o       = r_pkt_cnt;

  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_last    <= IDX_W'(NUM_SRC - 1);
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|s_axis_tvalid_i) begin
            r_grant <= w_arb_gnt;
            r_gidx  <= w_arb_idx;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_accept && w_tlast_g) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_last    <= r_gidx;
            r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int CW = 32;

  logic              clk_i = 1'b0;
  logic              s_rst_n_i;
  logic [NS*DW-1:0]  s_axis_tdata_i;
  logic [NS-1:0]     s_axis_tvalid_i;
  logic [NS-1:0]     s_axis_tlast_i;
  logic [NS-1:0]     s_axis_tready_o;
  logic              fifo_wr_en_o;
  logic [DW:0]       fifo_data_o;
  logic              fifo_full_i;
  logic [NS-1:0]     grant_o;
  logic              busy_o;
  logic [CW-1:0]     pkt_cnt_o;

  fifo_wr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i           (clk_i),
    .s_rst_n_i       (s_rst_n_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tready_o (s_axis_tready_o),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_full_i     (fifo_full_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .pkt_cnt_o       (pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int n_wr     = 0;

  logic [DW:0]   src_q [NS][$];
  logic [NS-1:0] src_en = '1;
  logic [DW:0]   exp_q [$];
  logic [NS-1:0] gnt_log [$];
  logic          prev_busy = 1'b0;
  logic [NS-1:0] smp_tready, smp_grant;
  logic          smp_wr;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      if (src_q[k].size() > 0 && src_en[k]) begin
        s_axis_tvalid_i[k]             = 1'b1;
        s_axis_tlast_i[k]              = src_q[k][0][DW];
        s_axis_tdata_i[k*DW +: DW]     = src_q[k][0][DW-1:0];
      end else begin
        s_axis_tvalid_i[k]             = 1'b0;
        s_axis_tlast_i[k]              = 1'b0;
        s_axis_tdata_i[k*DW +: DW]     = '0;
      end
    end
  endtask

  // One clock: sample/compare at negedge, advance sources just after posedge.
  task automatic step();
    logic [NS-1:0] hs;
    logic [DW:0]   w;
    @(negedge clk_i);
    hs         = s_axis_tvalid_i & s_axis_tready_o;
    smp_tready = s_axis_tready_o;
    smp_grant  = grant_o;
    smp_wr     = fifo_wr_en_o;
    if (busy_o && !prev_busy) gnt_log.push_back(grant_o);
    prev_busy = busy_o;
    chk(64'(fifo_wr_en_o & fifo_full_i), 64'd0, "no_write_when_full");
    chk(64'(s_axis_tready_o & ~grant_o), 64'd0, "tready_only_granted");
    if (fifo_wr_en_o) begin
      n_wr++;
      if (exp_q.size() == 0) chk(64'(fifo_data_o), 64'h1_FFFF_FFFF_F, "unexpected_write");
      else begin
        w = exp_q.pop_front();
        chk(64'(fifo_data_o), 64'(w), "fifo_word");
      end
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NS; k++) if (hs[k]) void'(src_q[k].pop_front());
    drive();
  endtask

  function automatic bit pending();
    for (int k = 0; k < NS; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int budget, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while ((pending() || busy_o) && steps < budget);
    chk(64'(pending() || busy_o), 64'd0, "idle_timeout");
  endtask

  task automatic load(input int k, input logic [DW:0] w);
    src_q[k].push_back(w);
  endtask

  task automatic pkt(input int k, input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      load(k, {(i == len - 1), base + DW'(i)});
      exp_q.push_back({(i == len - 1), base + DW'(i)});
    end
  endtask

  task automatic do_reset();
    s_rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    s_rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    prev_busy = 1'b0;
  endtask

  initial begin
    int st, wr0;
    s_rst_n_i       = 1'b0;
    s_axis_tdata_i  = '0;
    s_axis_tvalid_i = '0;
    s_axis_tlast_i  = '0;
    fifo_full_i     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #2;
    chk(64'(grant_o), 64'd0, "rst_grant");
    chk(64'(busy_o), 64'd0, "rst_busy");
    chk(64'(pkt_cnt_o), 64'd0, "rst_pkt_cnt");
    chk(64'(s_axis_tready_o), 64'd0, "rst_tready");
    chk(64'(fifo_wr_en_o), 64'd0, "rst_wr_en");
    do_reset();

    // Source 0: 3-beat packet A0..A2
    pkt(0, 32'hA0, 3);
    drive();
    chk(64'(grant_o), 64'd0, "t1_grant_idle");
    step();
    chk(64'(smp_wr), 64'd0, "t1_no_write_in_idle");
    chk(64'(smp_tready), 64'd0, "t1_no_tready_in_idle");
    chk(64'(grant_o), 64'h1, "t1_grant_latency");
    run_until_idle(20, st);
    chk(64'(st), 64'd3, "t1_remaining_cycles");
    chk(64'(pkt_cnt_o), 64'd1, "t1_pkt_cnt");
    chk(64'(exp_q.size()), 64'd0, "t1_all_written");

    // Sources 0,1,3 with 2-beat packets from reset (last = 3)
    do_reset();
    chk(64'(pkt_cnt_o), 64'd0, "t2_cnt_after_reset");
    gnt_log.delete();
    pkt(0, 32'hB0, 2);
    pkt(1, 32'hC0, 2);
    pkt(3, 32'hD0, 2);
    drive();
    run_until_idle(40, st);
    chk(64'(st), 64'd9, "t2_cycles_with_gaps");
    chk(64'(gnt_log.size()), 64'd3, "t2_num_grants");
    if (gnt_log.size() == 3) begin
      chk(64'(gnt_log[0]), 64'h1, "t2_grant0");
      chk(64'(gnt_log[1]), 64'h2, "t2_grant1");
      chk(64'(gnt_log[2]), 64'h8, "t2_grant2");
    end
    chk(64'(pkt_cnt_o), 64'd3, "t2_pkt_cnt");
    chk(64'(exp_q.size()), 64'd0, "t2_all_written");

    // Single-beat packet from source 1, then fairness between 1 and 2
    pkt(1, 32'hE0, 1);
    drive();
    step();
    step();
    chk(64'(smp_wr), 64'd1, "t3_single_write");
    chk(64'(busy_o), 64'd0, "t3_single_back_to_idle");
    gnt_log.delete();
    pkt(2, 32'hF0, 2);
    for (int i = 0; i < 2; i++) load(1, {(i == 1), 32'h100 + DW'(i)});
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b1, 32'h101});
    drive();
    run_until_idle(40, st);
    chk(64'(gnt_log.size()), 64'd2, "t3_num_grants");
    if (gnt_log.size() == 2) begin
      chk(64'(gnt_log[0]), 64'h4, "t3_fair_first");
      chk(64'(gnt_log[1]), 64'h2, "t3_fair_second");
    end
    chk(64'(pkt_cnt_o), 64'd6, "t3_pkt_cnt");

    // FIFO full for 4 cycles mid-packet of source 2
    wr0 = n_wr;
    pkt(2, 32'h200, 4);
    drive();
    step();
    step();
    fifo_full_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk(64'(smp_tready), 64'd0, "t4_tready_full");
      chk(64'(smp_wr), 64'd0, "t4_wr_full");
      chk(64'(smp_grant), 64'h4, "t4_grant_held");
    end
    fifo_full_i = 1'b0;
    step();
    chk(64'(smp_wr), 64'd1, "t4_resume");
    run_until_idle(20, st);
    chk(64'(n_wr - wr0), 64'd4, "t4_beat_count");
    chk(64'(pkt_cnt_o), 64'd7, "t4_pkt_cnt");
    chk(64'(exp_q.size()), 64'd0, "t4_all_written");

    // Source 3 drops tvalid mid-packet while source 0 requests
    gnt_log.delete();
    pkt(3, 32'h300, 3);
    drive();
    step();
    step();
    src_en[3] = 1'b0;
    pkt(0, 32'h400, 1);
    drive();
    for (int i = 0; i < 2; i++) begin
      step();
      chk(64'(smp_grant), 64'h8, "t5_grant_held");
      chk(64'(smp_wr), 64'd0, "t5_no_write");
    end
    src_en[3] = 1'b1;
    drive();
    run_until_idle(20, st);
    chk(64'(gnt_log.size()), 64'd2, "t5_num_grants");
    if (gnt_log.size() == 2) begin
      chk(64'(gnt_log[0]), 64'h8, "t5_first");
      chk(64'(gnt_log[1]), 64'h1, "t5_second");
    end
    chk(64'(pkt_cnt_o), 64'd9, "t5_pkt_cnt");

    // Async reset mid-packet of source 1
    load(1, {1'b0, 32'h500});
    load(1, {1'b0, 32'h501});
    load(1, {1'b0, 32'h502});
    load(1, {1'b1, 32'h503});
    exp_q.push_back({1'b0, 32'h500});
    exp_q.push_back({1'b0, 32'h501});
    drive();
    step();
    step();
    step();
    #2;
    s_rst_n_i = 1'b0;
    #1;
    chk(64'(grant_o), 64'd0, "t6_rst_grant");
    chk(64'(busy_o), 64'd0, "t6_rst_busy");
    chk(64'(s_axis_tready_o), 64'd0, "t6_rst_tready");
    chk(64'(fifo_wr_en_o), 64'd0, "t6_rst_wr_en");
    chk(64'(pkt_cnt_o), 64'd0, "t6_rst_pkt_cnt");
    pkt(0, 32'h600, 1);
    exp_q.push_back({1'b0, 32'h502});
    exp_q.push_back({1'b1, 32'h503});
    drive();
    @(posedge clk_i);
    #3;
    s_rst_n_i = 1'b1;
    prev_busy = 1'b0;
    gnt_log.delete();
    @(posedge clk_i);
    #1;
    run_until_idle(20, st);
    if (gnt_log.size() > 0) chk(64'(gnt_log[0]), 64'h1, "t6_src0_first");
    else chk(64'd0, 64'h1, "t6_no_grant");
    chk(64'(pkt_cnt_o), 64'd2, "t6_pkt_cnt");
    chk(64'(exp_q.size()), 64'd0, "t6_all_written");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
